// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared definitions for the 50 MHz timing blocks.
//   state_t           FSM encoding used by freq_meter
//   CLK_FREQ_DEFAULT  system clock frequency in Hz
//   gate_cnt_width()  bit width of a 0..cycles-1 counter, minimum 1
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned CLK_FREQ_DEFAULT = 50_000_000;

  function automatic int gate_cnt_width(input int unsigned cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/freq_meter_if.sv
// freq_meter_if: control/result bundle of the frequency meter.
//   start, cont                      requester -> meter
//   busy, freq_out, valid, overflow  meter -> requester
// master = requester side, slave = meter side.
interface freq_meter_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic             cont;
  logic             busy;
  logic [CNT_W-1:0] freq_out;
  logic             valid;
  logic             overflow;

  modport master (
    output start, cont,
    input  busy, freq_out, valid, overflow
  );

  modport slave (
    input  start, cont,
    output busy, freq_out, valid, overflow
  );
endinterface

// File: rtl/freq_meter_sync_edge_detect.sv
// sync_edge_detect: brings an asynchronous input into the clk domain and
// flags its rising edges.
//   clk       system clock
//   rst       asynchronous active-low reset
//   async_in  input asynchronous to clk
//   rise      one-cycle pulse per synchronized rising edge
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Both terms are flop outputs, so rise carries no path from async_in.
  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of sig_in over a gate of CLK_FREQ/GATE_DIV
// clk cycles and reports the result scaled to Hz.
//   clk, rst  system clock, asynchronous active-low reset
//   sig_in    signal under measurement (asynchronous)
//   bus       freq_meter_if.slave: start, cont in; busy, freq_out, valid,
//             overflow out (all registered)
//
// state | meaning
// IDLE  | waiting for start or cont
// GATE  | counting edges for GATE_CYCLES cycles
// DONE  | one cycle, result and valid presented
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = CLK_FREQ_DEFAULT,
  parameter int unsigned GATE_DIV    = 1,
  parameter int          CNT_W       = 32,
  parameter int          SYNC_STAGES = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     sig_in,
  freq_meter_if.slave bus
);

  localparam int unsigned       GATE_CYCLES = CLK_FREQ / GATE_DIV;
  localparam int                GATE_W      = gate_cnt_width(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST   = GATE_W'(GATE_CYCLES - 1);
  localparam int                PROD_W      = CNT_W + 32;

  state_t            state_q, state_d;
  logic [GATE_W-1:0] gate_cnt_q;
  logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic              rise;
  logic              gate_last;
  logic [PROD_W-1:0] product;
  logic              result_sat;
  logic [CNT_W-1:0]  result;
  logic              busy_q, valid_q, overflow_q;
  logic [CNT_W-1:0]  freq_q;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (sig_in),
    .rise     (rise)
  );

  assign gate_last = (state_q == GATE) && (gate_cnt_q == GATE_LAST);

  // Saturating edge count including the current cycle's rise, so the last
  // gate cycle is counted in the result registered on the way into DONE.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    if (rise && !(&edge_cnt_q)) edge_cnt_d = edge_cnt_q + CNT_W'(1);
  end

  assign product    = PROD_W'(edge_cnt_d) * PROD_W'(GATE_DIV);
  assign result_sat = (&edge_cnt_d) | (|product[PROD_W-1:CNT_W]);
  assign result     = result_sat ? '1 : product[CNT_W-1:0];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start || bus.cont) state_d = GATE;
      GATE:    if (gate_cnt_q == GATE_LAST) state_d = DONE;
      DONE:    state_d = bus.cont ? GATE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      freq_q     <= '0;
    end else begin
      state_q <= state_d;
      // Counters only run in GATE; holding them at zero elsewhere clears
      // them on every entry to GATE and drops rises seen during DONE.
      if (state_q == GATE) begin
        gate_cnt_q <= gate_cnt_q + GATE_W'(1);
        edge_cnt_q <= edge_cnt_d;
      end else begin
        gate_cnt_q <= '0;
        edge_cnt_q <= '0;
      end
      busy_q  <= (state_d != IDLE);
      valid_q <= gate_last;
      if (gate_last) begin
        freq_q     <= result;
        overflow_q <= result_sat;
      end
    end
  end

  assign bus.busy     = busy_q;
  assign bus.valid    = valid_q;
  assign bus.overflow = overflow_q;
  assign bus.freq_out = freq_q;

endmodule

// File: tb/tb_freq_meter.sv
module tb_freq_meter;

  localparam int CLK_FREQ = 1000;
  localparam int GATE_DIV = 10;
  localparam int RES_LAT  = 101;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sig_in = 1'b0;

  always #5 clk = ~clk;

  freq_meter_if #(.CNT_W(32)) bus_a ();
  freq_meter_if #(.CNT_W(4))  bus_b ();

  freq_meter #(.CLK_FREQ(CLK_FREQ), .GATE_DIV(GATE_DIV), .CNT_W(32), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst(rst), .sig_in(sig_in), .bus(bus_a.slave)
  );

  freq_meter #(.CLK_FREQ(CLK_FREQ), .GATE_DIV(GATE_DIV), .CNT_W(4), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .rst(rst), .sig_in(sig_in), .bus(bus_b.slave)
  );

  typedef struct {
    int unsigned cyc;
    logic [31:0] freq;
    logic        ovf;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int n_vec = 0;
  int n_err = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Square-wave source, phase-locked to the falling edge of clk.
  int   period = 0;
  logic hold_lvl = 1'b0;
  int   ph = 0;
  always @(negedge clk) begin
    if (period == 0) begin
      sig_in = hold_lvl;
      ph = 0;
    end else if (ph >= period / 2 - 1) begin
      sig_in = ~sig_in;
      ph = 0;
    end else begin
      ph = ph + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rst && bus_a.valid === 1'b1) begin
      if (q_a.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL a_unexpected_valid: valid=1 at cycle %0d, required 0", cyc);
      end else begin
        e = q_a.pop_front();
        check("a_valid_cycle", cyc, e.cyc);
        check("a_freq_out", bus_a.freq_out, e.freq);
        check("a_overflow", {31'b0, bus_a.overflow}, {31'b0, e.ovf});
        check("a_busy_at_valid", {31'b0, bus_a.busy}, 32'd1);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rst && bus_b.valid === 1'b1) begin
      if (q_b.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL b_unexpected_valid: valid=1 at cycle %0d, required 0", cyc);
      end else begin
        e = q_b.pop_front();
        check("b_valid_cycle", cyc, e.cyc);
        check("b_freq_out", {28'b0, bus_b.freq_out}, e.freq);
        check("b_overflow", {31'b0, bus_b.overflow}, {31'b0, e.ovf});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", q_a.size() + q_b.size());
      q_a.delete();
      q_b.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a_busy"},     {31'b0, bus_a.busy},     32'd0);
    check({tag, "_a_valid"},    {31'b0, bus_a.valid},    32'd0);
    check({tag, "_a_freq_out"}, bus_a.freq_out,          32'd0);
    check({tag, "_a_overflow"}, {31'b0, bus_a.overflow}, 32'd0);
    check({tag, "_b_busy"},     {31'b0, bus_b.busy},     32'd0);
    check({tag, "_b_freq_out"}, {28'b0, bus_b.freq_out}, 32'd0);
  endtask

  initial begin
    int unsigned t0;
    bus_a.start = 1'b0;
    bus_a.cont  = 1'b0;
    bus_b.start = 1'b0;
    bus_b.cont  = 1'b0;
    rst = 1'b0;
    tick(3);
    check_reset_outputs("por");
    rst = 1'b1;

    // Single shot, period 10: 10 edges per 100-cycle gate -> 100 Hz.
    period = 10;
    tick(30);
    t0 = cyc;
    q_a.push_back('{t0 + RES_LAT, 32'd100, 1'b0});
    bus_a.start = 1'b1;
    tick(1);
    bus_a.start = 1'b0;
    drain(300);
    while (cyc < t0 + RES_LAT + 1) tick(1);
    check("a_busy_after_done", {31'b0, bus_a.busy}, 32'd0);

    // Second start 30 cycles into the gate is ignored.
    tick(10);
    t0 = cyc;
    q_a.push_back('{t0 + RES_LAT, 32'd100, 1'b0});
    bus_a.start = 1'b1;
    tick(1);
    bus_a.start = 1'b0;
    tick(29);
    check("a_busy_mid_gate", {31'b0, bus_a.busy}, 32'd1);
    bus_a.start = 1'b1;
    tick(1);
    bus_a.start = 1'b0;
    drain(300);
    tick(150);

    // Static input high -> 0 Hz, no overflow.
    period = 0;
    hold_lvl = 1'b1;
    tick(20);
    t0 = cyc;
    q_a.push_back('{t0 + RES_LAT, 32'd0, 1'b0});
    bus_a.start = 1'b1;
    tick(1);
    bus_a.start = 1'b0;
    drain(300);
    tick(5);

    // Continuous, period 20 -> 50 Hz every 101 cycles; cont dropped in 3rd gate.
    period = 20;
    tick(40);
    t0 = cyc;
    q_a.push_back('{t0 + RES_LAT,     32'd50, 1'b0});
    q_a.push_back('{t0 + 2 * RES_LAT, 32'd50, 1'b0});
    q_a.push_back('{t0 + 3 * RES_LAT, 32'd50, 1'b0});
    bus_a.cont = 1'b1;
    while (cyc < t0 + 250) tick(1);
    bus_a.cont = 1'b0;
    drain(400);
    tick(300);
    check("a_busy_after_cont", {31'b0, bus_a.busy}, 32'd0);

    // Reset mid-gate: outputs clear at once, no result, FSM stays idle.
    period = 10;
    tick(30);
    bus_a.start = 1'b1;
    tick(1);
    bus_a.start = 1'b0;
    tick(50);
    check("a_busy_before_rst", {31'b0, bus_a.busy}, 32'd1);
    check("a_freq_before_rst", bus_a.freq_out, 32'd50);
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick(2);
    rst = 1'b1;
    tick(300);
    check("a_busy_idle_after_rst", {31'b0, bus_a.busy}, 32'd0);

    // 4-bit meter, period 4: 25 edges -> saturates at 15 with overflow.
    period = 4;
    tick(20);
    t0 = cyc;
    q_b.push_back('{t0 + RES_LAT, 32'd15, 1'b1});
    bus_b.start = 1'b1;
    tick(1);
    bus_b.start = 1'b0;
    drain(300);
    tick(5);

    // Following static measurement clears overflow.
    period = 0;
    hold_lvl = 1'b0;
    tick(20);
    t0 = cyc;
    q_b.push_back('{t0 + RES_LAT, 32'd0, 1'b0});
    bus_b.start = 1'b1;
    tick(1);
    bus_b.start = 1'b0;
    drain(300);
    tick(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
Measures the frequency of a slow, asynchronous square-wave input (divided clocks, switch/sensor toggles, external signals) against the 50 MHz system clock. It counts synchronized rising edges over a fixed gate window and reports the result in Hz, with a one-cycle valid strobe. It can run a single measurement per start pulse or measure continuously. It is the on-board check for divided-clock outputs and drives the 7-segment and LED status logic.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz.
GATE_DIV, 1, gate window = CLK_FREQ/GATE_DIV cycles (1/GATE_DIV s); must divide CLK_FREQ exactly.
CNT_W, 32, width of the edge counter and freq_out.
SYNC_STAGES, 2, synchronizer flops on sig_in (minimum 2).

Ports:
clk  input  1  system clock, 50 MHz.
rst  input  1  asynchronous, active-low reset.
sig_in  input  1  signal under measurement, asynchronous to clk.
start  input  1  single-cycle request to begin a measurement; sampled only in IDLE.
cont  input  1  continuous mode: when 1, a new gate starts automatically after each result.
busy  output  1  high while in GATE or DONE.
freq_out  output  CNT_W  last measured frequency in Hz, held until the next result.
valid  output  1  one-cycle pulse when freq_out updates.
overflow  output  1  last result saturated; updates with each valid.

Behaviour:
- Reset (rst=0, async): state=IDLE; synchronizer, previous-sample flop, gate counter and edge counter all 0; freq_out=0, valid=0, overflow=0, busy=0.
- Synchronizer: sig_in passes through SYNC_STAGES flops, then one edge flop holds the previous value. rise = sync_out & ~prev. A rise is seen SYNC_STAGES+1 clocks after the input edge. Input pulses shorter than 2 clk periods are not guaranteed to be seen.
- FSM states: IDLE, GATE, DONE.
  - IDLE: if start=1 or cont=1, go to GATE next cycle. Clear gate_cnt and edge_cnt on this transition.
  - GATE: gate_cnt counts 0..GATE_CYCLES-1, where GATE_CYCLES=CLK_FREQ/GATE_DIV. Every cycle with rise=1 increments edge_cnt, including the cycle gate_cnt==GATE_CYCLES-1. When gate_cnt==GATE_CYCLES-1, go to DONE.
  - DONE (exactly 1 cycle): freq_out <= edge_cnt*GATE_DIV, saturated to 2^CNT_W-1. overflow <= 1 if edge_cnt saturated or the product exceeds CNT_W bits, else 0. valid=1 in this cycle only. Next state: GATE if cont=1, clearing both counters; otherwise IDLE.
- Latency: start sampled at edge T → first gate cycle T+1 → DONE/valid in cycle T+1+GATE_CYCLES. Back-to-back continuous results are GATE_CYCLES+1 cycles apart. Rises that occur during DONE are not counted.
- edge_cnt saturates at all-ones and never wraps. gate_cnt is sized ceil(log2(GATE_CYCLES)) bits, minimum 1.
- start while busy is ignored, not queued. Simultaneous start and cont in IDLE act as one start.
- cont deasserted mid-gate: the current gate completes and reports, then the block returns to IDLE.
- sig_in held constant: the result is 0 Hz, valid still pulses, overflow=0.
- rst asserted mid-gate: the measurement is aborted with no valid pulse, and all outputs return to their reset values immediately.
- All outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package/include holds the state encodings (IDLE=2'd0, GATE=2'd1, DONE=2'd2) and the CLK_FREQ default constant, shared with the other 50 MHz timing blocks.
- One sub-module is natural: sync_edge_detect (parameter SYNC_STAGES; ports clk, rst, async_in, rise). Counters, FSM and saturation stay in freq_meter.

Test Plan:
All scenarios use CLK_FREQ=1000, GATE_DIV=10 (gate = 100 cycles) unless noted.
- Reset during operation: rst low in mid-gate → busy, valid, freq_out, overflow all 0 asynchronously; after release, with no start, the FSM stays in IDLE indefinitely.
- Single shot: start pulse, sig_in period 10 clk (50% duty) → exactly one valid, 101 cycles after start is sampled; freq_out=100 (±10 for phase); busy low the next cycle.
- Static input: sig_in held at 1, start → valid with freq_out=0, overflow=0.
- Continuous: cont=1, sig_in period 20 clk → valid pulses every 101 cycles, freq_out=50 (±10) each time; drop cont mid-gate → one more valid, then IDLE.
- Overflow: CNT_W=4, sig_in period 4 clk → 25 edges exceed 15 → freq_out=15, overflow=1; a following measurement with sig_in static → overflow=0.
- Ignored start: a second start 30 cycles into the gate → no extra valid, and timing of the first result is unchanged.
